mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port between the data requester (memory stage) and the instruction-fetch requester.
- Sits between those two stages and the memory/bus model.
- Grants one outstanding transaction at a time, with fixed data priority plus a fetch anti-starvation limit.
- Provides a watchdog timeout that completes a hung transaction with an error flag.

Parameters:
- MAX_STREAK, 4: max consecutive data grants while fetch is waiting; the next contended grant goes to fetch. Range 1-15.
- TIMEOUT, 0: cycles in BUSY without m_ack before forced error completion; 0 disables the watchdog. Counter width is 16 bits.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- d_req  in  1  data request; held until d_ack
- d_addr  in  32  data address
- d_write  in  1  1 = store
- d_wdata  in  32  store data
- d_extend  in  1  sign-extend loads
- d_width  in  2  access width code, passed through
- d_ack  out  1  data completion pulse
- d_err  out  1  valid with d_ack; 1 = timed out
- d_rdata  out  32  data read result
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  32  fetch address
- i_ack  out  1  fetch completion pulse
- i_err  out  1  valid with i_ack
- i_rdata  out  32  fetched word
- m_req  out  1  memory request
- m_addr  out  32  memory address
- m_write  out  1  memory write
- m_wdata  out  32  memory write data
- m_extend  out  1  memory extend
- m_width  out  2  memory width
- m_ack  in  1  memory completion, one-cycle pulse; m_rdata valid in that cycle
- m_rdata  in  32  memory read data
- busy  out  1  1 when state != IDLE

Behaviour:
- States: IDLE, BUSY_D, BUSY_I.
- Reset: state=IDLE; m_req=0; the m_* field registers are 0; d_ack=i_ack=d_err=i_err=0; held rdata registers are 0; streak=0; timer=0.
- Reset mid-transaction: IDLE on the next cycle, m_req=0, and no ack is issued. A later m_ack is ignored.
- IDLE, arbitration in cycle N:
  - If only d_req: grant data.
  - If only i_req: grant fetch.
  - If both and streak<MAX_STREAK: grant data and increment streak.
  - If both and streak==MAX_STREAK: grant fetch.
  - Streak clears on any fetch grant and on any data grant made while i_req=0.
- On grant, the requester's fields are registered into m_*. Fetch grants force m_write=0, m_wdata=0, m_extend=0, m_width=2'b10.
- State becomes BUSY_D or BUSY_I and m_req=1 from cycle N+1.
- BUSY_x while m_req=1, fields stable:
  - On m_ack in cycle M, the granted port's ack=1 combinationally in cycle M, with err=0.
  - The granted port's rdata = m_rdata in cycle M. The value is registered and held after M until that port's next completion.
  - m_req drops and state=IDLE at M+1.
  - Minimum request-to-ack latency is 1 cycle plus memory latency. There is always one IDLE cycle between transactions.
- Timeout (TIMEOUT>0):
  - timer clears on grant and increments each BUSY cycle without m_ack.
  - When timer==TIMEOUT-1 and m_ack=0, the port gets ack=1, err=1, and its held rdata becomes 0. m_req drops and state=IDLE next cycle.
  - m_ack in the same cycle as expiry wins: normal completion.
- The other port's ack is never asserted while one port is busy; its request simply waits.
- m_ack while IDLE is ignored.
- A requester dropping req while BUSY is illegal. The arbiter still completes the transaction and pulses ack.
- A req still high in the cycle after its ack is a new request.

Test Plan:
- Single data load: d_req=1, d_addr=0x100, memory acks 2 cycles after m_req rises with m_rdata=0xDEADBEEF -> m_req rises at N+1; d_ack pulses 1 cycle at N+3 with d_rdata=0xDEADBEEF and d_err=0; i_ack stays 0.
- Single fetch: i_req=1, i_addr=0x40 -> m_addr=0x40, m_write=0, m_width=2'b10; i_ack and i_rdata follow the m_ack cycle.
- Contention with MAX_STREAK=4: d_req and i_req held high continuously, 1-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I.
- Timeout with TIMEOUT=8: a data store is never acked -> d_ack=1 and d_err=1 exactly 8 BUSY cycles after m_req rises; m_req=0 the next cycle. A late m_ack in IDLE produces no ack.
- Reset mid-op: assert reset while in BUSY_I -> m_req=0, busy=0, i_ack never pulses. A subsequent d_req is served normally.
- Store passthrough: d_write=1, d_wdata=0x12345678, d_width=0, d_extend=1 -> m_* fields are held stable and equal to the inputs for the entire m_req high period.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the data (memory-stage) and instruction-fetch requesters.
// Fixed data priority with a fetch anti-starvation streak limit and an optional watchdog timeout.
module mem_arbiter #(
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  input  logic        d_extend,
  input  logic [1:0]  d_width,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [31:0] m_wdata,
  output logic        m_extend,
  output logic [1:0]  m_width,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  localparam logic [3:0]  STREAK_MAX = 4'(MAX_STREAK);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  streak_reg, streak_next;
  logic [15:0] timer_reg;
  logic [31:0] m_addr_reg, m_wdata_reg;
  logic        m_write_reg, m_extend_reg;
  logic [1:0]  m_width_reg;
  logic [31:0] d_rdata_reg, i_rdata_reg;
  logic        grant_d, grant_i, in_busy, expire, done;

  always_comb begin
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    state_next  = state_reg;
    streak_next = streak_reg;
    in_busy     = (state_reg != IDLE);
    expire      = (TIMEOUT != 0) && in_busy && !m_ack && (timer_reg == TIMER_LAST);
    // Reset wins over a completion arriving in the same cycle: no ack is issued.
    done        = in_busy && (m_ack || expire) && !reset;
    if (state_reg == IDLE) begin
      if (d_req && (!i_req || streak_reg < STREAK_MAX)) begin
        grant_d     = 1'b1;
        state_next  = BUSY_D;
        streak_next = i_req ? streak_reg + 4'd1 : 4'd0;
      end else if (i_req) begin
        grant_i     = 1'b1;
        state_next  = BUSY_I;
        streak_next = 4'd0;
      end
    end else if (done) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      streak_reg   <= 4'd0;
      timer_reg    <= 16'd0;
      m_addr_reg   <= 32'd0;
      m_wdata_reg  <= 32'd0;
      m_write_reg  <= 1'b0;
      m_extend_reg <= 1'b0;
      m_width_reg  <= 2'b00;
      d_rdata_reg  <= 32'd0;
      i_rdata_reg  <= 32'd0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
      if (grant_d) begin
        m_addr_reg   <= d_addr;
        m_write_reg  <= d_write;
        m_wdata_reg  <= d_wdata;
        m_extend_reg <= d_extend;
        m_width_reg  <= d_width;
      end else if (grant_i) begin
        m_addr_reg   <= i_addr;
        m_write_reg  <= 1'b0;
        m_wdata_reg  <= 32'd0;
        m_extend_reg <= 1'b0;
        m_width_reg  <= 2'b10;
      end
      if (grant_d || grant_i) begin
        timer_reg <= 16'd0;
      end else if (in_busy && !m_ack) begin
        timer_reg <= timer_reg + 16'd1;
      end
      if (d_ack) d_rdata_reg <= expire ? 32'd0 : m_rdata;
      if (i_ack) i_rdata_reg <= expire ? 32'd0 : m_rdata;
    end
  end

  assign busy     = in_busy;
  assign m_req    = in_busy;
  assign m_addr   = m_addr_reg;
  assign m_write  = m_write_reg;
  assign m_wdata  = m_wdata_reg;
  assign m_extend = m_extend_reg;
  assign m_width  = m_width_reg;

  // Completion is visible in the m_ack cycle itself; afterwards the held copy is shown.
  assign d_ack   = done && (state_reg == BUSY_D);
  assign i_ack   = done && (state_reg == BUSY_I);
  assign d_err   = d_ack && expire;
  assign i_err   = i_ack && expire;
  assign d_rdata = d_ack ? (expire ? 32'd0 : m_rdata) : d_rdata_reg;
  assign i_rdata = i_ack ? (expire ? 32'd0 : m_rdata) : i_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_STREAK=4, TIMEOUT=8).
// The bench acts as the memory model, acking by hand in each scenario.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_req, d_write, d_extend;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_width;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        m_req, m_write, m_extend;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_width;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        busy;

  int checks = 0;
  int passes = 0;

  mem_arbiter #(.MAX_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata),
    .d_extend(d_extend), .d_width(d_width),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata),
    .m_extend(m_extend), .m_width(m_width),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; d_req = 0; d_addr = 0; d_write = 0; d_wdata = 0; d_extend = 0; d_width = 0;
    i_req = 0; i_addr = 0; m_ack = 0; m_rdata = 0;
    next_cycle(); next_cycle(); #1;
    checks++; if (m_req !== 1'b0) $display("FAIL reset_mreq: got %0b want 0", m_req); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passes++;
    checks++; if ({d_ack, i_ack, d_err, i_err} !== 4'b0) $display("FAIL reset_acks: got %b want 0000", {d_ack, i_ack, d_err, i_err}); else passes++;
    checks++; if ({m_addr, m_wdata, m_write, m_extend, m_width} !== 68'd0) $display("FAIL reset_mfields: got %h want 0", {m_addr, m_wdata, m_write, m_extend, m_width}); else passes++;
    checks++; if ({d_rdata, i_rdata} !== 64'd0) $display("FAIL reset_rdata: got %h want 0", {d_rdata, i_rdata}); else passes++;
    next_cycle(); reset = 1'b0;
    $display("reset sequence done");
  endtask

  task automatic test_load();
    next_cycle(); d_req = 1; d_addr = 32'h100; d_write = 0; #1;   // cycle N
    checks++; if (m_req !== 1'b0) $display("FAIL load_mreq_n: got %0b want 0", m_req); else passes++;
    next_cycle(); #1;                                                // N+1
    checks++; if (m_req !== 1'b1) $display("FAIL load_mreq_n1: got %0b want 1", m_req); else passes++;
    checks++; if (m_addr !== 32'h100) $display("FAIL load_maddr: got %h want 00000100", m_addr); else passes++;
    next_cycle(); #1;                                                // N+2
    checks++; if (d_ack !== 1'b0) $display("FAIL load_early_ack: got %0b want 0", d_ack); else passes++;
    next_cycle(); m_ack = 1; m_rdata = 32'hDEADBEEF; #1;             // N+3
    checks++; if ({d_ack, d_err, i_ack} !== 3'b100) $display("FAIL load_ack: got %b want 100", {d_ack, d_err, i_ack}); else passes++;
    checks++; if (d_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h want deadbeef", d_rdata); else passes++;
    next_cycle(); m_ack = 0; m_rdata = 0; d_req = 0; #1;            // N+4
    checks++; if ({m_req, d_ack} !== 2'b00) $display("FAIL load_after: got %b want 00", {m_req, d_ack}); else passes++;
    checks++; if (d_rdata !== 32'hDEADBEEF) $display("FAIL load_hold: got %h want deadbeef", d_rdata); else passes++;
    $display("data load 0x100 -> 0x%h", d_rdata);
  endtask

  task automatic test_fetch();
    next_cycle(); i_req = 1; i_addr = 32'h40;
    next_cycle(); m_ack = 1; m_rdata = 32'hCAFEF00D; #1;
    checks++; if (m_addr !== 32'h40) $display("FAIL fetch_maddr: got %h want 00000040", m_addr); else passes++;
    checks++; if ({m_write, m_wdata, m_extend, m_width} !== {1'b0, 32'd0, 1'b0, 2'b10}) $display("FAIL fetch_fields: got %b/%h/%b/%b want 0/0/0/10", m_write, m_wdata, m_extend, m_width); else passes++;
    checks++; if ({i_ack, i_err, d_ack} !== 3'b100) $display("FAIL fetch_ack: got %b want 100", {i_ack, i_err, d_ack}); else passes++;
    checks++; if (i_rdata !== 32'hCAFEF00D) $display("FAIL fetch_rdata: got %h want cafef00d", i_rdata); else passes++;
    next_cycle(); m_ack = 0; m_rdata = 0; i_req = 0; #1;
    checks++; if ({m_req, i_ack, i_rdata} !== {2'b00, 32'hCAFEF00D}) $display("FAIL fetch_after: got %b/%h want 00/cafef00d", {m_req, i_ack}, i_rdata); else passes++;
    $display("fetch 0x40 -> 0x%h", i_rdata);
  endtask

  task automatic test_contention();
    logic exp_fetch [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic got_fetch [10];
    int   n = 0;
    int   both = 0;
    next_cycle(); d_req = 1; d_addr = 32'h500; d_write = 0; i_req = 1; i_addr = 32'h80;
    for (int c = 0; c < 60 && n < 10; c++) begin
      next_cycle(); m_ack = m_req; m_rdata = 32'h1000 + 32'(c); #1;
      if (d_ack && i_ack) both++;
      if (d_ack || i_ack) begin
        got_fetch[n] = i_ack;
        $display("contention grant %0d: %s", n, i_ack ? "I" : "D");
        n++;
      end
    end
    next_cycle(); d_req = 0; i_req = 0; m_ack = 0; m_rdata = 0;
    checks++; if (n !== 10) $display("FAIL contention_count: got %0d want 10", n); else passes++;
    checks++; if (both !== 0) $display("FAIL contention_dual_ack: got %0d want 0", both); else passes++;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_fetch[k] !== exp_fetch[k]) $display("FAIL contention_order[%0d]: got %s want %s", k, got_fetch[k] ? "I" : "D", exp_fetch[k] ? "I" : "D");
      else passes++;
    end
  endtask

  task automatic test_timeout();
    int busy_cnt = 0;
    int ack_at   = -1;
    logic err_seen = 0;
    logic [31:0] rd_seen = 32'hFFFFFFFF;
    next_cycle(); d_req = 1; d_addr = 32'h200; d_write = 1; d_wdata = 32'h55;
    for (int c = 0; c < 20 && ack_at < 0; c++) begin
      next_cycle(); #1;
      if (m_req) busy_cnt++;
      if (d_ack) begin ack_at = busy_cnt; err_seen = d_err; rd_seen = d_rdata; end
    end
    checks++; if (ack_at !== 8) $display("FAIL timeout_cycle: got %0d want 8", ack_at); else passes++;
    checks++; if ({err_seen, rd_seen} !== {1'b1, 32'd0}) $display("FAIL timeout_err: got %b/%h want 1/0", err_seen, rd_seen); else passes++;
    next_cycle(); d_req = 0; d_write = 0; #1;
    checks++; if ({m_req, d_rdata} !== {1'b0, 32'd0}) $display("FAIL timeout_after: got %b/%h want 0/0", m_req, d_rdata); else passes++;
    next_cycle(); m_ack = 1; m_rdata = 32'h77; #1;
    checks++; if ({d_ack, i_ack, busy} !== 3'b000) $display("FAIL timeout_late_ack: got %b want 000", {d_ack, i_ack, busy}); else passes++;
    next_cycle(); m_ack = 0; m_rdata = 0;
    $display("store 0x200 timed out after %0d busy cycles", ack_at);
  endtask

  task automatic test_reset_mid();
    next_cycle(); i_req = 1; i_addr = 32'h80;
    next_cycle(); #1;
    checks++; if (m_req !== 1'b1) $display("FAIL rstmid_mreq: got %0b want 1", m_req); else passes++;
    next_cycle(); reset = 1; m_ack = 1; m_rdata = 32'h99; #1;
    checks++; if (i_ack !== 1'b0) $display("FAIL rstmid_ack_in_reset: got %0b want 0", i_ack); else passes++;
    next_cycle(); reset = 0; m_ack = 0; i_req = 0; #1;
    checks++; if ({m_req, busy, i_ack} !== 3'b000) $display("FAIL rstmid_idle: got %b want 000", {m_req, busy, i_ack}); else passes++;
    next_cycle(); m_ack = 1; #1;
    checks++; if ({i_ack, d_ack, i_rdata} !== {2'b00, 32'd0}) $display("FAIL rstmid_late: got %b/%h want 00/0", {i_ack, d_ack}, i_rdata); else passes++;
    next_cycle(); m_ack = 0; d_req = 1; d_addr = 32'h300;
    next_cycle(); m_ack = 1; m_rdata = 32'h11112222; #1;
    checks++; if ({m_addr, d_ack, d_err, d_rdata} !== {32'h300, 2'b10, 32'h11112222}) $display("FAIL rstmid_serve: got %h/%b/%h want 300/10/11112222", m_addr, {d_ack, d_err}, d_rdata); else passes++;
    next_cycle(); m_ack = 0; m_rdata = 0; d_req = 0;
    $display("reset mid fetch, then data 0x300 -> 0x%h", d_rdata);
  endtask

  task automatic test_store_passthrough();
    logic [67:0] exp = {32'h400, 32'h12345678, 1'b1, 1'b1, 2'b00};
    next_cycle(); d_req = 1; d_addr = 32'h400; d_write = 1; d_wdata = 32'h12345678; d_width = 2'b00; d_extend = 1;
    next_cycle(); d_addr = 32'hFFFF0000; d_wdata = 32'hA5A5A5A5; d_width = 2'b11; d_extend = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin m_ack = 1; m_rdata = 32'h0; end
      #1;
      checks++;
      if ({m_addr, m_wdata, m_write, m_extend, m_width} !== exp || m_req !== 1'b1)
        $display("FAIL store_fields[%0d]: got %h req %0b want %h req 1", c, {m_addr, m_wdata, m_write, m_extend, m_width}, m_req, exp);
      else passes++;
      if (c < 3) next_cycle();
    end
    checks++; if ({d_ack, d_err} !== 2'b10) $display("FAIL store_ack: got %b want 10", {d_ack, d_err}); else passes++;
    next_cycle(); m_ack = 0; d_req = 0; d_write = 0; d_extend = 0; #1;
    checks++; if (m_req !== 1'b0) $display("FAIL store_after: got %0b want 0", m_req); else passes++;
    $display("store 0x400 <- 0x12345678 completed");
  endtask

  initial begin
    test_reset();
    test_load();
    test_fetch();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_store_passthrough();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
